// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, ID/EX bundle bit positions and MULTU FSM encoding
// for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULTU = 6'h19;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;
  localparam int MEM_READ    = 2;
  localparam int MEM_WRITE   = 1;
  localparam int MEM_BRANCH  = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
  } bundle_t;

  typedef struct packed {
    bundle_t b;
    logic    jump;
    logic    jr;
    logic    extsel;
    logic    multu;
    logic    illegal;
  } dec_t;

  function automatic bundle_t mk_bundle(input logic regdst, input logic [1:0] aluop,
                                        input logic alusrc, input logic memread,
                                        input logic memwrite, input logic branch,
                                        input logic regwrite, input logic memtoreg);
    bundle_t b;
    b = '0;
    b.ex[EX_REGDST]               = regdst;
    b.ex[EX_ALUOP_HI:EX_ALUOP_LO] = aluop;
    b.ex[EX_ALUSRC]               = alusrc;
    b.mem[MEM_READ]               = memread;
    b.mem[MEM_WRITE]              = memwrite;
    b.mem[MEM_BRANCH]             = branch;
    b.wb[WB_REGWRITE]             = regwrite;
    b.wb[WB_MEMTOREG]             = memtoreg;
    return b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Pure combinational ID-stage decode: control bundles plus jump/extend flags.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_LW: begin
        dec.b      = mk_bundle(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        dec.extsel = 1'b1;
      end
      OP_SW: begin
        dec.b      = mk_bundle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        dec.extsel = 1'b1;
      end
      OP_BEQ: begin
        dec.b      = mk_bundle(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        dec.extsel = 1'b1;
      end
      OP_ANDI: begin
        dec.b      = mk_bundle(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        dec.extsel = 1'b1;
      end
      OP_J: begin
        dec.jump   = 1'b1;
        dec.extsel = 1'b1;
      end
      OP_RTYPE: begin
        // JR carries no datapath work past ID, so its bundles stay empty
        if (funct == FN_JR) begin
          dec.jump = 1'b1;
          dec.jr   = 1'b1;
        end else begin
          dec.b     = mk_bundle(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
          dec.multu = (funct == FN_MULTU);
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decode, load-use and MULTU stalls, branch/jump flushes,
// and the registered ID/EX control bundles.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT       = 32,
  parameter bit FLUSH_ON_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       id_valid,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic [4:0] IDEX_Rt,
  input  logic       IDEX_MemRead,
  input  logic       branch_taken,
  output logic [3:0] EX,
  output logic [2:0] MEM,
  output logic [1:0] WB,
  output logic       Jump,
  output logic       JR,
  output logic       ExtendSel,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFFlush,
  output logic       mul_start,
  output logic       mul_busy,
  output logic       illegal
);

  localparam int CW = $clog2(MUL_LAT);

  dec_t             dec;
  bundle_t          nb;
  mul_state_e       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             load_use, accept, mul_go;

  ctrl_decode u_dec (
    .opcode (OpCode),
    .funct  (Funct),
    .dec    (dec)
  );

  assign load_use  = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                     ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
  assign mul_busy  = (state != MUL_IDLE);
  // An instruction is consumed only when nothing higher-priority is in the way
  assign accept    = id_valid && !branch_taken && !mul_busy && !load_use;
  assign mul_go    = accept && dec.multu;
  assign mul_start = mul_go && !rst;

  assign Jump      = id_valid && dec.jump;
  assign JR        = id_valid && dec.jr;
  assign ExtendSel = dec.extsel;

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFFlush   = 1'b0;
    if (rst) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFFlush   = 1'b1;
    end else if (branch_taken) begin
      IFFlush   = 1'b1;
    end else if (mul_busy || load_use) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (Jump && FLUSH_ON_JUMP) begin
      IFFlush   = 1'b1;
    end
  end

  assign nb = (accept && !dec.illegal) ? dec.b : '0;

  // BUSY spans MUL_LAT-1 cycles, DONE adds the last stall cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      MUL_IDLE: if (mul_go) begin
        state_n = MUL_BUSY;
        cnt_n   = CW'(MUL_LAT - 1);
      end
      MUL_BUSY: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = MUL_DONE;
      end
      MUL_DONE: state_n = MUL_IDLE;
      default:  state_n = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MUL_IDLE;
      cnt     <= '0;
      EX      <= '0;
      MEM     <= '0;
      WB      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      EX      <= nb.ex;
      MEM     <= nb.mem;
      WB      <= nb.wb;
      illegal <= accept && dec.illegal;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench: directed vector table, MULTU/reset sequences, and
// randomized traffic against a cycle-count reference model.
module tb_pipe_ctrl_unit;

  localparam int MUL_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OpCode, Funct;
  logic       id_valid;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic       IDEX_MemRead, branch_taken;

  logic [3:0] ex1, ex0;
  logic [2:0] mem1, mem0;
  logic [1:0] wb1, wb0;
  logic       jmp1, jr1, ext1, pcw1, ifw1, iff1, ms1, mb1, ill1;
  logic       jmp0, jr0, ext0, pcw0, ifw0, iff0, ms0, mb0, ill0;

  int n_chk  = 0;
  int n_fail = 0;
  int mul_left = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.MUL_LAT(MUL_LAT), .FLUSH_ON_JUMP(1'b1)) u_f1 (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .id_valid(id_valid),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IDEX_Rt(IDEX_Rt),
    .IDEX_MemRead(IDEX_MemRead), .branch_taken(branch_taken),
    .EX(ex1), .MEM(mem1), .WB(wb1), .Jump(jmp1), .JR(jr1), .ExtendSel(ext1),
    .PCWrite(pcw1), .IFIDWrite(ifw1), .IFFlush(iff1), .mul_start(ms1),
    .mul_busy(mb1), .illegal(ill1));

  pipe_ctrl_unit #(.MUL_LAT(MUL_LAT), .FLUSH_ON_JUMP(1'b0)) u_f0 (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .id_valid(id_valid),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IDEX_Rt(IDEX_Rt),
    .IDEX_MemRead(IDEX_MemRead), .branch_taken(branch_taken),
    .EX(ex0), .MEM(mem0), .WB(wb0), .Jump(jmp0), .JR(jr0), .ExtendSel(ext0),
    .PCWrite(pcw0), .IFIDWrite(ifw0), .IFFlush(iff0), .mul_start(ms0),
    .mul_busy(mb0), .illegal(ill0));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction table
  function automatic void ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                  output logic [8:0] b, output bit jmp, output bit jr,
                                  output bit ext, output bit mul, output bit ill);
    b = '0; jmp = 0; jr = 0; ext = 0; mul = 0; ill = 0;
    case (op)
      6'h23: begin b = 9'b0001_100_11; ext = 1; end
      6'h2B: begin b = 9'b0001_010_00; ext = 1; end
      6'h04: begin b = 9'b0010_001_00; ext = 1; end
      6'h0C: begin b = 9'b0001_000_10; ext = 1; end
      6'h02: begin jmp = 1; ext = 1; end
      6'h00: begin
        if (fn == 6'h08) begin jmp = 1; jr = 1; end
        else begin b = 9'b1100_000_10; mul = (fn == 6'h19); end
      end
      default: ill = 1;
    endcase
  endfunction

  // One model-checked cycle; inputs already applied just after a negedge
  task automatic step();
    logic [8:0] b, eb;
    bit jmp, jr, ext, mul, ill, busy, lu, acc, ms, iffx;
    ref_dec(OpCode, Funct, b, jmp, jr, ext, mul, ill);
    busy = (mul_left > 0);
    lu   = IDEX_MemRead && IDEX_Rt != 0 && (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt);
    acc  = id_valid && !branch_taken && !busy && !lu;
    ms   = acc && mul;
    iffx = !branch_taken && !busy && !lu && id_valid && jmp;
    #1;
    chk("comb_f1", {jmp1, jr1, ext1, pcw1, ifw1, iff1, ms1, mb1},
        {id_valid && jmp, id_valid && jr, ext, branch_taken || !(busy || lu),
         branch_taken || !(busy || lu), branch_taken || iffx, ms, busy});
    chk("comb_f0", {jmp0, jr0, ext0, pcw0, ifw0, iff0, ms0, mb0},
        {id_valid && jmp, id_valid && jr, ext, branch_taken || !(busy || lu),
         branch_taken || !(busy || lu), branch_taken, ms, busy});
    @(posedge clk);
    if (busy) mul_left--;
    if (ms) mul_left = MUL_LAT;
    eb = (acc && !ill) ? b : 9'd0;
    #1;
    chk("bund_f1", {ex1, mem1, wb1, ill1}, {eb, acc && ill});
    chk("bund_f0", {ex0, mem0, wb0, ill0}, {eb, acc && ill});
    @(negedge clk);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic v,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                       input logic xmr, input logic br);
    OpCode = op; Funct = fn; id_valid = v; IFID_Rs = rs; IFID_Rt = rt;
    IDEX_Rt = xrt; IDEX_MemRead = xmr; branch_taken = br;
  endtask

  typedef struct {
    logic [5:0] op, fn;
    logic       v;
    logic [4:0] rs, rt, xrt;
    logic       xmr, br;
    logic [8:0] bund;
    logic       pcw, iff1, iff0, jmp, ill;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int busy_cnt, pcw_lo;
    logic [5:0] ops[8];
    logic [5:0] fns[4];

    tbl[0]  = '{6'h23, 6'h00, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 9'b0001_100_11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{6'h2B, 6'h00, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 9'b0001_010_00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{6'h04, 6'h00, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 9'b0010_001_00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{6'h0C, 6'h00, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 9'b0001_000_10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{6'h00, 6'h20, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 9'b1100_000_10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{6'h00, 6'h08, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 9'd0,           1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{6'h02, 6'h00, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 9'd0,           1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{6'h3F, 6'h00, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 9'd0,           1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{6'h23, 6'h00, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 9'd0,           1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{6'h00, 6'h20, 1'b1, 5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 9'd0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{6'h00, 6'h20, 1'b1, 5'd8, 5'd2, 5'd8, 1'b0, 1'b0, 9'b1100_000_10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{6'h00, 6'h20, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 9'b1100_000_10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{6'h00, 6'h20, 1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 9'd0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{6'h23, 6'h00, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 9'd0,           1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{6'h02, 6'h00, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 9'd0,           1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{6'h02, 6'h00, 1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 9'd0,           1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    drive(6'h23, 6'h00, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("rst_bund", {ex1, mem1, wb1, ill1, ms1, mb1}, 16'd0);
    chk("rst_steer", {pcw1, ifw1, iff1, pcw0, ifw0, iff0}, 6'b001_001);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, each from an idle multiplier
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].fn, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].xrt,
            tbl[i].xmr, tbl[i].br);
      #1;
      chk($sformatf("vec%0d_steer", i), {pcw1, ifw1, iff1, iff0, jmp1, jmp0},
          {tbl[i].pcw, tbl[i].pcw, tbl[i].iff1, tbl[i].iff0, tbl[i].jmp, tbl[i].jmp});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_bund", i), {ex1, mem1, wb1, ill1}, {tbl[i].bund, tbl[i].ill});
      chk($sformatf("vec%0d_bund0", i), {ex0, mem0, wb0, ill0}, {tbl[i].bund, tbl[i].ill});
      @(negedge clk);
    end

    // MULTU: one start pulse, MUL_LAT stall cycles, then normal flow
    drive(6'h00, 6'h19, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step();
    busy_cnt = 0; pcw_lo = 0;
    for (int i = 0; i < 8; i++) begin
      drive(6'h00, 6'h20, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, (i == 1));
      #1;
      busy_cnt += int'(mb1);
      pcw_lo   += int'(!pcw1 && !branch_taken);
      step();
    end
    chk("mul_busy_cycles", 16'(busy_cnt), 16'(MUL_LAT));
    chk("mul_stall_cycles", 16'(pcw_lo), 16'(MUL_LAT - 1));

    // MULTU squashed by a taken branch never starts
    drive(6'h00, 6'h19, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    step();
    drive(6'h00, 6'h20, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step();

    // Reset while BUSY with count 2: everything clears without a clock edge
    drive(6'h00, 6'h19, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step();
    drive(6'h00, 6'h20, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_busy", {mb1, ms1, mb0, ms0}, 4'd0);
    chk("rstmid_bund", {ex1, mem1, wb1, ill1}, 10'd0);
    chk("rstmid_steer", {pcw1, ifw1, iff1}, 3'b001);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    mul_left = 0;
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic against the model
    ops = '{6'h23, 6'h2B, 6'h04, 6'h0C, 6'h00, 6'h02, 6'h3F, 6'h03};
    fns = '{6'h20, 6'h08, 6'h19, 6'h25};
    for (int i = 0; i < 400; i++) begin
      drive(ops[$urandom_range(7)], fns[$urandom_range(3)], ($urandom_range(9) != 0),
            5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
            ($urandom_range(2) == 0), ($urandom_range(9) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
